rr_mux_arbiter_4: RTL and testbench

Round-robin arbiter that shares one 4:1 data multiplexer between four requesters and delivers the selected word through a single registered valid/ready output stage. Each cycle the output register is free, one pending requester is chosen by rotating priority, its data is captured, and it receives a one-cycle acknowledge. An optional per-requester lock extends a grant into a bounded burst. It sits in front of any single-consumer sink that the four producers share.

---
 rtl/rr_arb_pkg.sv | 14 +
 rtl/mux_4_1.sv | 12 +
 rtl/rr_pick_4.sv | 27 ++
 rtl/rr_mux_arbiter_4.sv | 107 ++++++++++
 tb/tb_rr_mux_arbiter_4.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package rr_arb_pkg;

    typedef logic [1:0] src_t;
    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int N_REQ = 4;

    // Burst counter width; never collapse to zero bits when bursts are disabled.
    function automatic int cnt_w(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/mux_4_1.sv
// Parameterised 4:1 word multiplexer.
module mux_4_1 #(
    parameter int W = 4
) (
    input  logic [3:0][W-1:0] d,
    input  logic [1:0]        sel,
    output logic [W-1:0]      y
);

    assign y = d[sel];

endmodule

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority pick: first set req bit at or after ptr.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  src_t             ptr,
    output logic [N_REQ-1:0] gnt,
    output src_t             idx
);

    src_t cand;

    // Scan farthest-first so the candidate closest to ptr overwrites last.
    always_comb begin
        gnt  = '0;
        idx  = ptr;
        cand = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + src_t'(k);
            if (req[cand]) begin
                idx = cand;
                gnt = 4'b0001 << cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter over four requesters with optional locked bursts,
// feeding one registered valid/ready output stage.
module rr_mux_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [N_REQ-1:0] ack,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output src_t             out_src,
    input  logic             out_ready
);

    localparam int CW = cnt_w(MAX_BURST);

    arb_state_t              state;
    src_t                    owner;
    src_t                    ptr;
    logic [CW-1:0]           cnt;

    logic [N_REQ-1:0][W-1:0] d_all;
    logic                    load;
    logic                    keep;
    src_t                    base;
    logic [N_REQ-1:0]        pick_gnt;
    src_t                    pick_idx;
    src_t                    g;
    logic [N_REQ-1:0]        gnt_oh;
    logic [W-1:0]            sel_data;
    logic                    burst_more;

    assign d_all = {d3, d2, d1, d0};
    assign load  = (~out_valid | out_ready) & (|req);

    // A burst owner that stopped requesting hands off to owner+1 in the same cycle.
    assign keep = (state == BURST) & req[owner];
    assign base = (state == BURST) ? src_t'(owner + 2'd1) : ptr;

    rr_pick_4 u_pick (
        .req (req),
        .ptr (base),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign g      = keep ? owner : pick_idx;
    assign gnt_oh = keep ? (4'b0001 << owner) : pick_gnt;
    assign ack    = (load & rst_n) ? gnt_oh : '0;

    mux_4_1 #(.W(W)) u_mux (
        .d   (d_all),
        .sel (g),
        .y   (sel_data)
    );

    assign burst_more = (g == owner) & lock[owner] & ((int'(cnt) + 1) < MAX_BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            state     <= IDLE;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= g;
            case (state)
                IDLE: begin
                    if (lock[g] && MAX_BURST > 1) begin
                        state <= BURST;
                        owner <= g;
                        cnt   <= CW'(1);
                    end else begin
                        ptr <= g + 2'd1;
                    end
                end
                BURST: begin
                    if (burst_more) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                        ptr   <= g + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench: stimulus pushes expected beats, a monitor pops and checks them.
module tb_rr_mux_arbiter_4;

    typedef struct {
        logic [1:0] src;
        logic [3:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b1111;
    logic [3:0] lock = 4'b0000;
    logic [3:0] dv [4];
    logic [3:0] ack;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_ready = 1'b1;

    beat_t q [$];
    int    ncmp = 0;
    int    nerr = 0;

    initial begin
        dv[0] = 4'd1; dv[1] = 4'd2; dv[2] = 4'd3; dv[3] = 4'd4;
    end

    always #5 clk = ~clk;

    rr_mux_arbiter_4 #(.W(4), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .d0        (dv[0]),
        .d1        (dv[1]),
        .d2        (dv[2]),
        .d3        (dv[3]),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh2i(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // One cycle of stimulus; a nonzero expected ack means a word is loaded this cycle.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                        input logic [3:0] exp_ack);
        beat_t b;
        @(posedge clk); #1;
        req = r; lock = l; out_ready = rdy;
        @(negedge clk);
        check("ack", {28'd0, ack}, {28'd0, exp_ack});
        if (exp_ack != 4'd0) begin
            b.src  = oh2i(exp_ack);
            b.data = dv[b.src];
            q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL unexpected_beat: got src %0d data %0h, expected none", out_src, out_data);
            end else begin
                e = q.pop_front();
                check("beat_src", {30'd0, out_src}, {30'd0, e.src});
                check("beat_data", {28'd0, out_data}, {28'd0, e.data});
            end
        end
    end

    initial begin
        beat_t b;
        // Reset state, with requests already pending.
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {28'd0, out_data}, 32'd0);
        check("rst_src", {30'd0, out_src}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fair rotation.
        step(4'b1111, 4'b0000, 1'b1, 4'b0001);
        step(4'b1111, 4'b0000, 1'b1, 4'b0010);
        step(4'b1111, 4'b0000, 1'b1, 4'b0100);
        step(4'b1111, 4'b0000, 1'b1, 4'b1000);
        step(4'b1111, 4'b0000, 1'b1, 4'b0001);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        check("drained_valid", {31'd0, out_valid}, 32'd0);

        // Reset pulse, then skip idle requesters from ptr=0.
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'b1010, 4'b0000, 1'b1, 4'b0010);
        step(4'b1010, 4'b0000, 1'b1, 4'b1000);
        step(4'b1010, 4'b0000, 1'b1, 4'b0010);
        step(4'b1010, 4'b0000, 1'b1, 4'b1000);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);

        // Backpressure: word 0 frozen for three stalled cycles.
        step(4'b1111, 4'b0000, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 4'b0000, 1'b0, 4'b0000);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_src", {30'd0, out_src}, 32'd0);
            check("bp_data", {28'd0, out_data}, 32'd1);
        end
        step(4'b1111, 4'b0000, 1'b1, 4'b0010);
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);

        // Burst cap from ptr=2: 0,0,0,0,1,0,0,0,0,1.
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) step(4'b0011, 4'b0001, 1'b1, 4'b0001);
            step(4'b0011, 4'b0001, 1'b1, 4'b0010);
        end
        step(4'b0000, 4'b0000, 1'b1, 4'b0000);
        dv[2] = 4'hC; dv[3] = 4'h7;

        // Burst cut short: owner 2 drops after two grants, 3 takes over, ptr becomes 0.
        step(4'b1100, 4'b0100, 1'b1, 4'b0100);
        step(4'b1100, 4'b0100, 1'b1, 4'b0100);
        step(4'b1000, 4'b0100, 1'b1, 4'b1000);
        step(4'b1111, 4'b0000, 1'b1, 4'b0001);

        // Async reset in the middle of a burst with a word held.
        step(4'b0011, 4'b0010, 1'b1, 4'b0010);
        step(4'b0011, 4'b0010, 1'b1, 4'b0010);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_data", {28'd0, out_data}, 32'd0);
        check("arst_src", {30'd0, out_src}, 32'd0);
        check("arst_ack", {28'd0, ack}, 32'd0);
        q.delete();
        req = 4'b1000; lock = 4'b0000;
        @(posedge clk); #1;
        check("arst_hold_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        #1;
        check("rel_ack", {28'd0, ack}, 32'd8);
        b.src = 2'd3; b.data = dv[3];
        q.push_back(b);
        @(posedge clk); #1;
        check("rel_valid", {31'd0, out_valid}, 32'd1);
        check("rel_src", {30'd0, out_src}, 32'd3);
        req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
